// File: rtl/cache_pkg.sv
// Shared cache definitions: data word and block geometry, the refill line
// type and the refill sequencer state encoding.
package cache_pkg;

  localparam int WORD_W      = 64;
  localparam int BLOCK_WORDS = 4;
  localparam int IDX_W       = $clog2(BLOCK_WORDS);
  localparam int LINE_W      = WORD_W * BLOCK_WORDS;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_ISSUE = 2'd1,
    REFILL_DRAIN = 2'd2,
    REFILL_DONE  = 2'd3
  } refill_state_e;

  // Word slot inside a block reached by stepping 'count' words from 'start'
  function automatic logic [IDX_W-1:0] block_slot(input logic [IDX_W-1:0] start,
                                                  input logic [IDX_W-1:0] count);
    return start + count;
  endfunction

endpackage

// File: rtl/refill_timer.sv
// Response watchdog for the refill unit. Counts cycles while enabled and
// flags 'expired' in the cycle whose clock edge brings the count to TIMEOUT,
// so the owner can react on that same edge.
module refill_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter: cleared by the owner, advanced while waiting
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && !clear && (count_r == LAST_CNT);

endmodule

// File: rtl/cache_refill_unit.sv
// Cache block refill unit: fetches BLOCK_WORDS words from main memory with up
// to BLOCK_WORDS reads in flight, assembles them into a line and pulses
// refill_valid, or pulses refill_error if memory stops answering.
// Build option: CRITICAL_WORD_FIRST_EN starts the fill at the missing word and
// wraps around the block; without it fills always start at the block base.
module cache_refill_unit #(
  parameter int WORD_W      = cache_pkg::WORD_W,
  parameter int ADDR_W      = 32,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          refill_req,
  input  logic [ADDR_W-1:0]             refill_addr,
  output logic                          refill_busy,
  output logic                          refill_valid,
  output logic [WORD_W*BLOCK_WORDS-1:0] refill_line,
  output logic                          refill_error,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ready,
  input  logic                          mem_rvalid,
  input  logic [WORD_W-1:0]             mem_rdata
);

  import cache_pkg::*;

  localparam int                 IDX_BITS    = $clog2(BLOCK_WORDS);
  localparam int                 LINE_BITS   = WORD_W * BLOCK_WORDS;
  localparam logic [IDX_BITS:0]  LAST_CNT    = (IDX_BITS + 1)'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0]  OFFSET_MASK = ADDR_W'(BLOCK_WORDS - 1);

  refill_state_e          state_r;
  logic [ADDR_W-1:0]      base_r;
  logic [IDX_BITS-1:0]    start_r;
  logic [IDX_BITS:0]      req_cnt_r;
  logic [IDX_BITS:0]      rsp_cnt_r;
  logic [LINE_BITS-1:0]   line_r;

  logic [ADDR_W-1:0]      base_s;
  logic [IDX_BITS-1:0]    start_s;
  logic [IDX_BITS-1:0]    req_idx_next_s;
  logic [IDX_BITS-1:0]    rsp_slot_s;
  logic                   active_s;
  logic                   req_accept_s;
  logic                   rsp_accept_s;
  logic                   last_req_s;
  logic                   last_rsp_s;
  logic                   outstanding_s;
  logic                   timer_clear_s;
  logic                   timer_expired_s;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_s = refill_addr[IDX_BITS-1:0];
`else
  assign start_s = {IDX_BITS{1'b0}};
`endif

  assign base_s         = refill_addr & ~OFFSET_MASK;
  assign active_s       = (state_r == REFILL_ISSUE) || (state_r == REFILL_DRAIN);
  assign req_accept_s   = (state_r == REFILL_ISSUE) && mem_req && mem_ready;
  assign rsp_accept_s   = active_s && mem_rvalid;
  assign last_req_s     = req_accept_s && (req_cnt_r == LAST_CNT);
  assign last_rsp_s     = rsp_accept_s && (rsp_cnt_r == LAST_CNT);
  assign req_idx_next_s = start_r + req_cnt_r[IDX_BITS-1:0] + 1'b1;
  assign rsp_slot_s     = block_slot(start_r, rsp_cnt_r[IDX_BITS-1:0]);
  // The watchdog only runs while a read is in flight; each returned beat or a
  // fresh refill restarts the wait.
  assign outstanding_s  = active_s && (req_cnt_r != rsp_cnt_r);
  assign timer_clear_s  = (state_r == REFILL_IDLE) || rsp_accept_s;
  assign refill_line    = line_r;

  refill_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear_s),
    .enable  (outstanding_s),
    .expired (timer_expired_s)
  );

  // Refill sequencer: state, counters, line assembly and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= REFILL_IDLE;
      base_r       <= {ADDR_W{1'b0}};
      start_r      <= {IDX_BITS{1'b0}};
      req_cnt_r    <= {(IDX_BITS + 1){1'b0}};
      rsp_cnt_r    <= {(IDX_BITS + 1){1'b0}};
      line_r       <= {LINE_BITS{1'b0}};
      refill_busy  <= 1'b0;
      refill_valid <= 1'b0;
      refill_error <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        REFILL_IDLE: begin
          refill_valid <= 1'b0;
          refill_error <= 1'b0;
          if (refill_req) begin
            state_r     <= REFILL_ISSUE;
            base_r      <= base_s;
            start_r     <= start_s;
            req_cnt_r   <= {(IDX_BITS + 1){1'b0}};
            rsp_cnt_r   <= {(IDX_BITS + 1){1'b0}};
            line_r      <= {LINE_BITS{1'b0}};
            refill_busy <= 1'b1;
            mem_req     <= 1'b1;
            mem_addr    <= base_s | ADDR_W'(start_s);
          end else begin
            state_r <= REFILL_IDLE;
          end
        end
        REFILL_ISSUE, REFILL_DRAIN: begin
          if (timer_expired_s) begin
            // Memory went silent: drop the partial line and report it
            state_r      <= REFILL_IDLE;
            line_r       <= {LINE_BITS{1'b0}};
            req_cnt_r    <= {(IDX_BITS + 1){1'b0}};
            rsp_cnt_r    <= {(IDX_BITS + 1){1'b0}};
            refill_busy  <= 1'b0;
            refill_error <= 1'b1;
            mem_req      <= 1'b0;
          end else begin
            if (rsp_accept_s) begin
              line_r[WORD_W*rsp_slot_s +: WORD_W] <= mem_rdata;
              rsp_cnt_r <= rsp_cnt_r + 1'b1;
            end
            if (req_accept_s) begin
              req_cnt_r <= req_cnt_r + 1'b1;
              mem_addr  <= base_r | ADDR_W'(req_idx_next_s);
              if (last_req_s) begin
                mem_req <= 1'b0;
                state_r <= REFILL_DRAIN;
              end
            end
            // The final beat wins even when the last request is accepted in
            // the same cycle (zero-latency memory skips DRAIN entirely).
            if (last_rsp_s) begin
              state_r      <= REFILL_DONE;
              mem_req      <= 1'b0;
              refill_valid <= 1'b1;
            end
          end
        end
        REFILL_DONE: begin
          state_r      <= REFILL_IDLE;
          refill_valid <= 1'b0;
          refill_busy  <= 1'b0;
          mem_req      <= 1'b0;
        end
        default: begin
          state_r      <= REFILL_IDLE;
          refill_busy  <= 1'b0;
          refill_valid <= 1'b0;
          refill_error <= 1'b0;
          mem_req      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_refill_unit.md
CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001 SHALL have parameter WORD_W, default 64, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, word-address width.
REQ-003 SHALL have parameter BLOCK_WORDS, default 4, words per cache block (power of two).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a read response.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port refill_req, input, 1, cache requests a block fill (sampled only in IDLE).
REQ-008 SHALL have port refill_addr, input, ADDR_W, missing word address.
REQ-009 SHALL have port refill_busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port refill_valid, output, 1, one-cycle pulse when refill_line is complete.
REQ-011 SHALL have port refill_line, output, WORD_W*BLOCK_WORDS, word i at bits [WORD_W*i +: WORD_W].
REQ-012 SHALL have port refill_error, output, 1, one-cycle pulse on timeout.
REQ-013 SHALL have port mem_req, output, 1, read request to main memory.
REQ-014 SHALL have port mem_addr, output, ADDR_W, word address of the current request.
REQ-015 SHALL have port mem_ready, input, 1, memory accepts the request when mem_req and mem_ready are both high.
REQ-016 SHALL have ports mem_rvalid, input, 1, and mem_rdata, input, WORD_W; responses return in request order.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; any state -> IDLE on timeout.
REQ-018 IDLE: when refill_req=1, SHALL latch base = refill_addr with the low log2(BLOCK_WORDS) bits cleared, latch the start index, clear both counters, and enter ISSUE next cycle.
REQ-019 ISSUE: SHALL hold mem_req=1 and increment req_cnt on each accepted handshake; mem_addr = base + ((start + req_cnt) mod BLOCK_WORDS); enter DRAIN once BLOCK_WORDS requests are accepted.
REQ-020 SHALL allow up to BLOCK_WORDS outstanding requests; a response accepted in the same cycle as a request SHALL be counted correctly.
REQ-021 SHALL write each mem_rvalid beat into line slot (start + rsp_cnt) mod BLOCK_WORDS, then increment rsp_cnt.
REQ-022 SHALL enter DONE on the cycle after the final response, whether it arrives in ISSUE or DRAIN; DONE SHALL pulse refill_valid for exactly one cycle and return to IDLE.
REQ-023 refill_line SHALL hold its value until the next refill starts.
REQ-024 The timeout counter SHALL reset on every mem_rvalid and on refill start, and SHALL increment while responses are outstanding. On reaching TIMEOUT the block SHALL pulse refill_error, discard the partial line, and go to IDLE.
REQ-025 SHALL ignore mem_rvalid in IDLE and DONE, and SHALL ignore refill_req when not in IDLE.
REQ-026 SHALL accept back-to-back refills: a refill_req arriving the cycle after DONE is taken.

Reset
REQ-027 On reset=1 at a clock edge, SHALL enter IDLE and set refill_busy, refill_valid, refill_error, mem_req=0, mem_addr=0, refill_line=0, and all counters to 0.
REQ-028 Reset mid-refill SHALL abandon the refill with no refill_valid or refill_error pulse; late responses SHALL be ignored.

Configuration
REQ-029 With CRITICAL_WORD_FIRST_EN defined, start SHALL be refill_addr[log2(BLOCK_WORDS)-1:0], and requests SHALL wrap around the block.
REQ-030 Without CRITICAL_WORD_FIRST_EN, start SHALL be 0, giving sequential fills from base.

Structure
REQ-031 Package cache_pkg SHALL hold WORD_W, BLOCK_WORDS, the line typedef and the refill state enum, shared with the cache.
REQ-032 The timeout counter SHALL be the sub-module refill_timer (clear, enable, expired).

Verification
REQ-033 refill_addr=0x103, mem_ready=1, 1-cycle latency, data=0xA0..0xA3 -> mem_addr 0x100..0x103 without the macro (0x103,0x100,0x101,0x102 with it); one refill_valid pulse; refill_line={A3,A2,A1,A0}.
REQ-034 mem_ready low for 3 cycles mid-ISSUE -> mem_addr stable while stalled; no duplicate or skipped request; correct line.
REQ-035 No mem_rvalid after issue -> refill_error pulses exactly TIMEOUT=255 cycles later; no refill_valid; IDLE.
REQ-036 reset asserted after 2 responses, then 2 stray mem_rvalid -> outputs 0; no pulses; next refill clean.
REQ-037 refill_req held high continuously -> refills back-to-back, one refill_valid per block, with refill_req ignored while busy.
